// File: rtl/uart_tx_fifo_ctrl_if.sv
// Handshake bundle between the TX FIFO drain sequencer, the FIFO read port,
// the UART TX shifter and the APB status/control registers.
interface uart_tx_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int GAP_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16
);
    logic                  en;
    logic                  flush;
    logic [GAP_WIDTH-1:0]  gap_cycles;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_en;
    logic                  tx_busy;
    logic                  tx_done;
    logic                  tx_start;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  busy;
    logic                  byte_sent;
    logic                  flush_done;
    logic [CNT_WIDTH-1:0]  sent_count;

    // slave = the sequencer itself, master = everything around it
    modport slave (
        input  en, flush, gap_cycles, fifo_empty, fifo_rd_data, tx_busy, tx_done,
        output fifo_rd_en, tx_start, tx_data, busy, byte_sent, flush_done, sent_count
    );

    modport master (
        output en, flush, gap_cycles, fifo_empty, fifo_rd_data, tx_busy, tx_done,
        input  fifo_rd_en, tx_start, tx_data, busy, byte_sent, flush_done, sent_count
    );
endinterface

// File: rtl/uart_tx_fifo_ctrl.sv
// Drains the UART TX FIFO into the TX shifter one byte per frame, with a
// programmable inter-frame gap, FIFO flush and a completed-frame counter.
module uart_tx_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int GAP_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input logic               clk,
    input logic               rst,
    uart_tx_fifo_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_START,
        S_WAIT,
        S_GAP,
        S_FLUSH
    } state_t;

    state_t                state;
    logic                  flush_pend;
    logic [GAP_WIDTH-1:0]  gap_cnt;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic [CNT_WIDTH-1:0]  sent_count_q;
    logic                  byte_sent_q;
    logic                  flush_done_q;

    // NOTE: all state updates use non-blocking assignments, so where two
    // assignments to one register fire in the same cycle the later one wins;
    // flush_pend relies on this (set by flush, cleared on entering FLUSH).
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            flush_pend   <= 1'b0;
            gap_cnt      <= '0;
            tx_data_q    <= '0;
            sent_count_q <= '0;
            byte_sent_q  <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            byte_sent_q  <= 1'b0;
            flush_done_q <= 1'b0;
            if (bus.flush) flush_pend <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (flush_pend || bus.flush) begin
                        flush_pend <= 1'b0;
                        state      <= S_FLUSH;
                    end else if (bus.en && !bus.fifo_empty && !bus.tx_busy) begin
                        state <= S_POP;
                    end
                end
                S_POP: begin
                    tx_data_q <= bus.fifo_rd_data;
                    state     <= S_START;
                end
                S_START: state <= S_WAIT;
                S_WAIT: begin
                    if (bus.tx_done) begin
                        byte_sent_q  <= 1'b1;
                        sent_count_q <= sent_count_q + CNT_WIDTH'(1);
                        if (bus.gap_cycles == '0) begin
                            state <= S_IDLE;
                        end else begin
                            gap_cnt <= bus.gap_cycles;
                            state   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    // gap_cnt holds the GAP cycles still to spend, this one included
                    if (gap_cnt == GAP_WIDTH'(1)) state <= S_IDLE;
                    gap_cnt <= gap_cnt - GAP_WIDTH'(1);
                end
                S_FLUSH: begin
                    if (bus.fifo_empty) begin
                        flush_done_q <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The flush pop follows fifo_empty directly so the last byte is never over-read.
    assign bus.fifo_rd_en = (state == S_POP) || ((state == S_FLUSH) && !bus.fifo_empty);
    assign bus.tx_start   = (state == S_START);
    assign bus.busy       = (state != S_IDLE);
    assign bus.tx_data    = tx_data_q;
    assign bus.byte_sent  = byte_sent_q;
    assign bus.flush_done = flush_done_q;
    assign bus.sent_count = sent_count_q;

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Bench for uart_tx_fifo_ctrl: queue-based FIFO and frame-timer transmitter
// models, a per-cycle scoreboard, an IDLE decision table and directed sequences.
module tb_uart_tx_fifo_ctrl;
    localparam int DW = 8;
    localparam int GW = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_fifo_ctrl_if #(.DATA_WIDTH(DW), .GAP_WIDTH(GW), .CNT_WIDTH(CW)) bus ();
    uart_tx_fifo_ctrl #(.DATA_WIDTH(DW), .GAP_WIDTH(GW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    // narrow counter instance so the wrap-around is reachable in a short run
    uart_tx_fifo_ctrl_if #(.DATA_WIDTH(DW), .GAP_WIDTH(GW), .CNT_WIDTH(3)) bus2 ();
    uart_tx_fifo_ctrl #(.DATA_WIDTH(DW), .GAP_WIDTH(GW), .CNT_WIDTH(3)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // environment models
    logic [7:0] fq[$];
    int         frame_len     = 3;
    int         tx_cnt        = 0;
    bit         tx_busy_force = 1'b0;
    bit         tx_done_force = 1'b0;

    // scoreboard
    bit         frame_open    = 1'b0;
    int         exp_count     = 0;
    bit         exp_byte_sent = 1'b0;
    int         last_done_cyc = -1;
    int         last_done_gap = 0;
    int         last_pop_cyc  = -10;
    logic [7:0] last_pop_byte = 8'h00;
    int         n_start = 0, n_pops = 0, n_flush_done = 0, n_bad_pop = 0;
    logic [7:0] tx_log[$], pop_log[$], push_log[$];
    int         pop_cycles[$], done_cycles[$], start_cycles[$];

    typedef struct {
        bit en;
        bit has_byte;
        bit tx_busy;
        bit flush;
        bit exp_rd_en;
        bit exp_busy;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic drive_io();
        bus.fifo_empty   = (fq.size() == 0);
        bus.fifo_rd_data = (fq.size() != 0) ? fq[0] : 8'h00;
        bus.tx_busy      = (tx_cnt != 0) || tx_busy_force;
        bus.tx_done      = (tx_cnt == 1) || tx_done_force;
    endtask

    // One clock cycle: score the cycle that is ending, then let the models react to the edge.
    task automatic step();
        bit pop_now, start_now, done_open, rst_now;
        drive_io();
        #1;
        rst_now   = rst;
        pop_now   = (bus.fifo_rd_en === 1'b1);
        start_now = (bus.tx_start === 1'b1);
        done_open = 1'b0;
        if (!rst_now) begin
            check("sent_count", int'(bus.sent_count), exp_count);
            check("byte_sent", int'(bus.byte_sent), int'(exp_byte_sent));
            if (bus.flush_done === 1'b1) n_flush_done++;
            if (pop_now && last_done_cyc >= 0)
                check("gap_before_pop", int'(cyc - last_done_cyc >= last_done_gap + 2), 1);
            if (start_now) begin
                check("start_after_pop", cyc, last_pop_cyc + 1);
                check("start_data", int'(bus.tx_data), int'(last_pop_byte));
                tx_log.push_back(bus.tx_data);
                start_cycles.push_back(cyc);
                n_start++;
                frame_open = 1'b1;
            end else if (bus.tx_done && frame_open) begin
                done_open     = 1'b1;
                frame_open    = 1'b0;
                last_done_cyc = cyc;
                last_done_gap = int'(bus.gap_cycles);
                done_cycles.push_back(cyc);
            end
        end
        if (pop_now) begin
            if (fq.size() == 0) n_bad_pop++;
            else begin
                last_pop_byte = fq[0];
                last_pop_cyc  = cyc;
                pop_log.push_back(fq[0]);
                pop_cycles.push_back(cyc);
                n_pops++;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        if (pop_now && fq.size() != 0) void'(fq.pop_front());
        if (start_now) tx_cnt = frame_len;
        else if (tx_cnt > 0) tx_cnt--;
        if (rst_now) begin
            exp_count     = 0;
            exp_byte_sent = 1'b0;
            frame_open    = 1'b0;
            last_done_cyc = -1;
        end else begin
            exp_byte_sent = done_open;
            if (done_open) exp_count = (exp_count + 1) % 65536;
        end
        drive_io();
        #1;
    endtask

    task automatic clear_logs();
        tx_log.delete(); pop_log.delete(); push_log.delete();
        pop_cycles.delete(); done_cycles.delete(); start_cycles.delete();
        n_start = 0; n_pops = 0; n_flush_done = 0;
    endtask

    task automatic do_reset();
        // NOTE: bench stimulus is driven with blocking assignments from tasks,
        // away from the clock edge, so the DUT never races its inputs.
        bus.en = 1'b0; bus.flush = 1'b0;
        tx_busy_force = 1'b0; tx_done_force = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        fq.delete();
        tx_cnt = 0;
        clear_logs();
        drive_io();
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ok, n2, n_flush_req, j;
        logic s_prev;
        logic [7:0] b;

        bus.en = 1'b0; bus.flush = 1'b0; bus.gap_cycles = '0;
        bus2.en = 1'b0; bus2.flush = 1'b0; bus2.gap_cycles = '0;
        bus2.fifo_empty = 1'b1; bus2.fifo_rd_data = 8'h3C;
        bus2.tx_busy = 1'b0; bus2.tx_done = 1'b0;
        drive_io();

        //            en has tx_b fl  rd  busy
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        // IDLE decision table: one cycle after each input pattern
        for (int i = 0; i < 7; i++) begin
            do_reset();
            if (vecs[i].has_byte) fq.push_back(8'h40 + 8'(i));
            bus.en        = vecs[i].en;
            tx_busy_force = vecs[i].tx_busy;
            bus.flush     = vecs[i].flush;
            step();
            bus.flush = 1'b0;
            check($sformatf("vec%0d_rd_en", i), int'(bus.fifo_rd_en), int'(vecs[i].exp_rd_en));
            check($sformatf("vec%0d_busy", i), int'(bus.busy), int'(vecs[i].exp_busy));
        end

        // 1: reset values, then a single byte with its exact latency
        do_reset();
        check("rst_rd_en", int'(bus.fifo_rd_en), 0);
        check("rst_tx_start", int'(bus.tx_start), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_byte_sent", int'(bus.byte_sent), 0);
        check("rst_flush_done", int'(bus.flush_done), 0);
        check("rst_sent_count", int'(bus.sent_count), 0);
        check("rst_tx_data", int'(bus.tx_data), 0);
        bus.gap_cycles = 8'd0;
        frame_len = 3;
        fq.push_back(8'hA5);
        bus.en = 1'b1;
        step();
        check("t1_pop", int'(bus.fifo_rd_en), 1);
        check("t1_no_start_yet", int'(bus.tx_start), 0);
        step();
        check("t1_start", int'(bus.tx_start), 1);
        check("t1_tx_data", int'(bus.tx_data), 'hA5);
        check("t1_pop_once", int'(bus.fifo_rd_en), 0);
        step();
        check("t1_start_pulse", int'(bus.tx_start), 0);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            if (bus.byte_sent) ok = 1;
        end
        check("t1_byte_sent_seen", ok, 1);
        check("t1_sent_count", int'(bus.sent_count), 1);

        // 2: three frames with a 4-cycle gap; tx_start spacing is frame + gap + 3
        do_reset();
        bus.gap_cycles = 8'd4;
        frame_len = 2;
        fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
        bus.en = 1'b1;
        for (int i = 0; i < 200 && bus.sent_count != 16'd3; i++) step();
        step();
        check("t2_sent_count", int'(bus.sent_count), 3);
        check("t2_frames", tx_log.size(), 3);
        if (tx_log.size() == 3) begin
            check("t2_byte0", int'(tx_log[0]), 'h11);
            check("t2_byte1", int'(tx_log[1]), 'h22);
            check("t2_byte2", int'(tx_log[2]), 'h33);
        end
        if (pop_cycles.size() == 3 && done_cycles.size() == 3 && start_cycles.size() == 3) begin
            for (int i = 1; i < 3; i++) begin
                // done, 4 GAP cycles, one IDLE cycle, then POP
                check($sformatf("t2_done_to_pop%0d", i), pop_cycles[i] - done_cycles[i-1], 6);
                check($sformatf("t2_start_spacing%0d", i), start_cycles[i] - start_cycles[i-1],
                      frame_len + 4 + 3);
            end
        end

        // 3: flush during frame 1 of 5
        do_reset();
        bus.gap_cycles = 8'd0;
        frame_len = 5;
        for (int i = 0; i < 5; i++) fq.push_back(8'h31 + 8'(i));
        bus.en = 1'b1;
        for (int i = 0; i < 10 && n_start == 0; i++) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        for (int i = 0; i < 100 && (n_flush_done == 0 || bus.busy); i++) step();
        repeat (5) step();
        check("t3_flush_done_once", n_flush_done, 1);
        check("t3_sent_count", int'(bus.sent_count), 1);
        check("t3_frames", tx_log.size(), 1);
        check("t3_all_popped", pop_log.size(), 5);
        check("t3_fifo_left", fq.size(), 0);
        if (pop_cycles.size() == 5 && done_cycles.size() == 1) begin
            check("t3_flush_after_frame", int'(pop_cycles[1] > done_cycles[0]), 1);
            for (int i = 2; i < 5; i++)
                check($sformatf("t3_consecutive%0d", i), pop_cycles[i] - pop_cycles[i-1], 1);
        end

        // 4: spurious tx_done on an empty FIFO, then a busy transmitter holds off the pop
        do_reset();
        bus.en = 1'b1;
        tx_done_force = 1'b1;
        step();
        tx_done_force = 1'b0;
        repeat (5) step();
        check("t4_no_pop", n_pops, 0);
        check("t4_no_start", n_start, 0);
        check("t4_count_kept", int'(bus.sent_count), 0);
        tx_busy_force = 1'b1;
        fq.push_back(8'h77);
        repeat (6) step();
        check("t4_held_no_pop", n_pops, 0);
        check("t4_held_idle", int'(bus.busy), 0);
        tx_busy_force = 1'b0;
        step();
        check("t4_pop_after_busy", int'(bus.fifo_rd_en), 1);
        for (int i = 0; i < 30 && bus.sent_count != 16'd1; i++) step();
        check("t4_sent", int'(bus.sent_count), 1);

        // 5: reset in the middle of a frame
        do_reset();
        frame_len = 6;
        fq.push_back(8'h81); fq.push_back(8'h82);
        bus.en = 1'b1;
        for (int i = 0; i < 60 && n_start < 2; i++) step();
        step(); step();
        check("t5_pre_count", int'(bus.sent_count), 1);
        rst = 1'b1;
        step();
        check("t5_rd_en", int'(bus.fifo_rd_en), 0);
        check("t5_tx_start", int'(bus.tx_start), 0);
        check("t5_busy", int'(bus.busy), 0);
        check("t5_byte_sent", int'(bus.byte_sent), 0);
        check("t5_flush_done", int'(bus.flush_done), 0);
        check("t5_count_cleared", int'(bus.sent_count), 0);
        rst = 1'b0;
        fq.push_back(8'h5C);
        for (int i = 0; i < 60 && !(n_start == 3 && bus.sent_count == 16'd1); i++) step();
        check("t5_resume_count", int'(bus.sent_count), 1);
        check("t5_resume_frames", n_start, 3);
        if (tx_log.size() == 3) check("t5_resume_byte", int'(tx_log[2]), 'h5C);

        // randomized traffic against the scoreboard
        do_reset();
        n_flush_req = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0 && fq.size() < 6) begin
                b = 8'($urandom);
                fq.push_back(b);
                push_log.push_back(b);
            end
            if ($urandom_range(0, 15) == 0) bus.en = ~bus.en;
            if ($urandom_range(0, 29) == 0) bus.gap_cycles = 8'($urandom_range(0, 3));
            if (tx_cnt == 0) frame_len = $urandom_range(1, 4);
            bus.flush = ($urandom_range(0, 49) == 0);
            if (bus.flush) n_flush_req++;
            step();
            bus.flush = 1'b0;
        end
        bus.en = 1'b1;
        ok = 0;
        for (int i = 0; i < 600 && !ok; i++) begin
            step();
            if (fq.size() == 0 && !bus.busy && tx_cnt == 0 && !frame_open) ok = 1;
        end
        repeat (3) step();
        check("rand_drained", ok, 1);
        check("rand_pop_total", pop_log.size(), push_log.size());
        j = 0;
        for (int i = 0; i < pop_log.size() && i < push_log.size(); i++)
            if (pop_log[i] === push_log[i]) j++;
        check("rand_pop_order", j, pop_log.size());
        j = 0;
        for (int i = 0; i < push_log.size() && j < tx_log.size(); i++)
            if (push_log[i] === tx_log[j]) j++;
        check("rand_tx_in_order", j, tx_log.size());
        check("rand_count", int'(bus.sent_count), n_start % 65536);
        check("rand_flush_done_bound", int'(n_flush_done <= n_flush_req), 1);
        check("pops_while_empty", n_bad_pop, 0);

        // 6: counter wrap on the narrow-counter instance (7 + 1 -> 0)
        bus2.fifo_empty = 1'b0;
        bus2.en = 1'b1;
        n2 = 0;
        s_prev = 1'b0;
        for (int i = 0; i < 200 && n2 < 8; i++) begin
            @(posedge clk);
            #1;
            bus2.tx_done = s_prev;
            s_prev = bus2.tx_start;
            if (bus2.byte_sent) begin
                n2++;
                if (n2 == 7) check("wrap_before", int'(bus2.sent_count), 7);
                if (n2 == 8) check("wrap_to_zero", int'(bus2.sent_count), 0);
            end
        end
        check("wrap_frames", n2, 8);
        bus2.en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
